// File: rtl/fm_synth_pkg.sv
// Shared definitions for the FM synthesizer audio path: I2S receiver FSM
// states, synchronizer depth and the default DAC word width.
package fm_synth_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_rx_state_t;

  localparam int unsigned SYNC_STAGES          = 2;
  localparam int unsigned NUM_BITS_DAC_DEFAULT = 24;

endpackage

// File: rtl/i2s_rx_sync.sv
// Single-bit input conditioner: SYNC_STAGES-flop synchronizer followed by one
// delay flop. Provides the synced level and a one-cycle rising-edge pulse.
module i2s_rx_sync
  import fm_synth_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   dly_q;
  logic                   dly_d;

  // Next values: shift the pin into the synchronizer chain, delay the synced level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and delay registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples the bit clock, word select and data in the
// AXI clock domain, deserializes left/right words MSB first and presents each
// complete stereo pair on a one-deep valid/ready output register.
// Optional build macro: I2S_RX_ERR_CNT_EN adds a saturating 16-bit err_count.
module i2s_rx
  import fm_synth_pkg::*;
#(
  parameter int unsigned NUM_BITS_DAC = NUM_BITS_DAC_DEFAULT
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    s_clk,
  input  logic                    word_select,
  input  logic                    serial_data,
  output logic [NUM_BITS_DAC-1:0] m_left,
  output logic [NUM_BITS_DAC-1:0] m_right,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    overrun,
  output logic                    frame_err,
`ifdef I2S_RX_ERR_CNT_EN
  output logic [15:0]             err_count,
`endif
  input  logic                    err_clr
);

  localparam int unsigned           CNT_W    = $clog2(NUM_BITS_DAC + 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(NUM_BITS_DAC);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(NUM_BITS_DAC - 1);

  logic sclk_rise;
  logic ws_s;
  logic sd_s;

  i2s_rx_sync u_sync_sclk (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .d     (s_clk),
    .q     (),
    .rise  (sclk_rise)
  );

  i2s_rx_sync u_sync_ws (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .d     (word_select),
    .q     (ws_s),
    .rise  ()
  );

  i2s_rx_sync u_sync_sd (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .d     (serial_data),
    .q     (sd_s),
    .rise  ()
  );

  i2s_rx_state_t           state_q, state_d;
  logic                    ws_prev_q, ws_prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_BITS_DAC-1:0] shift_q, shift_d;
  logic [NUM_BITS_DAC-1:0] left_stage_q, left_stage_d;
  logic                    left_ok_q, left_ok_d;
  logic [NUM_BITS_DAC-1:0] m_left_q, m_left_d;
  logic [NUM_BITS_DAC-1:0] m_right_q, m_right_d;
  logic                    m_valid_q, m_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_err_q, frame_err_d;

  logic [NUM_BITS_DAC-1:0] word_full;
  logic                    pair_form;
  logic                    frame_ev;
  logic                    ovr_ev;
  logic                    hs;

  // Bit processing, slot tracking and output-register next state
  always_comb begin
    state_d      = state_q;
    ws_prev_d    = ws_prev_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    left_stage_d = left_stage_q;
    left_ok_d    = left_ok_q;
    m_left_d     = m_left_q;
    m_right_d    = m_right_q;
    m_valid_d    = m_valid_q;
    pair_form    = 1'b0;
    frame_ev     = 1'b0;
    ovr_ev       = 1'b0;
    word_full    = {shift_q[NUM_BITS_DAC-2:0], sd_s};
    hs           = m_valid_q & m_ready;

    if (sclk_rise) begin
      ws_prev_d = ws_s;
      if (ws_s != ws_prev_q) begin
        // The bit on a WS change edge belongs to the previous slot; drop it.
        cnt_d = '0;
        case (state_q)
          ST_SYNC: begin
            if (!ws_s) state_d = ST_LEFT;
          end
          default: begin
            if (cnt_q < CNT_FULL) begin
              frame_ev  = 1'b1;
              left_ok_d = 1'b0;
            end
            state_d = ws_s ? ST_RIGHT : ST_LEFT;
          end
        endcase
      end else if (cnt_q < CNT_FULL) begin
        shift_d = word_full;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          case (state_q)
            ST_LEFT: begin
              left_stage_d = word_full;
              left_ok_d    = 1'b1;
            end
            ST_RIGHT: begin
              if (left_ok_q) begin
                pair_form = 1'b1;
                left_ok_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end

    // Pair lands in the output register if it is empty or being drained now
    if (pair_form) begin
      if (!m_valid_q || hs) begin
        m_left_d  = left_stage_q;
        m_right_d = word_full;
        m_valid_d = 1'b1;
      end else begin
        ovr_ev = 1'b1;
      end
    end else if (hs) begin
      m_valid_d = 1'b0;
    end

    overrun_d   = ovr_ev   | (overrun_q   & ~err_clr);
    frame_err_d = frame_ev | (frame_err_q & ~err_clr);
  end

  // Receiver state, staging and output registers
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= ST_SYNC;
      ws_prev_q    <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      left_stage_q <= '0;
      left_ok_q    <= 1'b0;
      m_left_q     <= '0;
      m_right_q    <= '0;
      m_valid_q    <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ws_prev_q    <= ws_prev_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      left_stage_q <= left_stage_d;
      left_ok_q    <= left_ok_d;
      m_left_q     <= m_left_d;
      m_right_q    <= m_right_d;
      m_valid_q    <= m_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign m_left    = m_left_q;
  assign m_right   = m_right_q;
  assign m_valid   = m_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

`ifdef I2S_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating error counter; a new error event takes priority over clear
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ovr_ev || frame_ev) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end else if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  // Error counter register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) err_cnt_q <= '0;
    else                err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: reset/idle, sync from mid-frame, table of frames
// with m_ready high, backpressure/overrun and handshake coincidence.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_clk = 1'b0;
  logic        ws = 1'b0;
  logic        sd = 1'b0;
  logic [23:0] m_left;
  logic [23:0] m_right;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        overrun;
  logic        frame_err;
  logic        err_clr = 1'b0;
`ifdef I2S_RX_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  always #5 clk = ~clk;

  i2s_rx #(.NUM_BITS_DAC(24)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_clk         (s_clk),
    .word_select   (ws),
    .serial_data   (sd),
    .m_left        (m_left),
    .m_right       (m_right),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .overrun       (overrun),
    .frame_err     (frame_err),
`ifdef I2S_RX_ERR_CNT_EN
    .err_count     (err_count),
`endif
    .err_clr       (err_clr)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          vcnt = 0;
  int          rise_cyc = -1;
  int          last_rise_cyc = 0;
  int          lsb_cyc = 0;
  logic        vprev = 1'b0;
  logic [47:0] hq[$];

  // Handshake monitor: DUT outputs are registered, so pre-edge values are stable here
  always @(posedge clk) begin
    if (m_valid && !vprev) rise_cyc = cyc;
    vprev = m_valid;
    if (m_valid) vcnt++;
    if (m_valid && m_ready) hq.push_back({m_left, m_right});
    cyc++;
  end

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One I2S bit: data changes with s_clk low, s_clk high half-period of 4 clocks
  task automatic send_bit(input logic w, input logic b, input logic pulse);
    s_clk = 1'b0;
    ws    = w;
    sd    = b;
    repeat (4) @(negedge clk);
    s_clk = 1'b1;
    last_rise_cyc = cyc;
    if (pulse) begin
      repeat (2) @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_slot(input logic w, input logic [23:0] word, input int nbits,
                           input int npad, input logic pulse);
    send_bit(w, 1'b1, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w, word[23-i], pulse && (i == nbits - 1));
      if (i == nbits - 1) lsb_cyc = last_rise_cyc;
    end
    for (int i = 0; i < npad; i++) send_bit(w, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int lbits,
                            input logic pulse);
    send_slot(1'b0, l, lbits, (lbits == 24) ? 7 : 0, 1'b0);
    send_slot(1'b1, r, 24, 7, pulse);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          lbits;
    int          exp_n;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{24'h7FFFFF, 24'h800001, 24, 1, 24'h7FFFFF, 24'h800001, 1'b0};
    vecs[1] = '{24'hAAAAAA, 24'h111111, 20, 0, 24'h000000, 24'h000000, 1'b1};
    vecs[2] = '{24'h123456, 24'h654321, 24, 1, 24'h123456, 24'h654321, 1'b0};
    vecs[3] = '{24'h000000, 24'hFFFFFF, 24, 1, 24'h000000, 24'hFFFFFF, 1'b0};
    vecs[4] = '{24'hA5A5A5, 24'h5A5A5A, 24, 1, 24'hA5A5A5, 24'h5A5A5A, 1'b0};

    // Reset held while inputs toggle
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s_clk = ~s_clk;
      ws    = i[1];
      sd    = i[0];
      m_ready = i[2];
    end
    @(negedge clk);
    chk("rst_m_valid", 48'(m_valid), 48'h0);
    chk("rst_m_left", 48'(m_left), 48'h0);
    chk("rst_m_right", 48'(m_right), 48'h0);
    chk("rst_overrun", 48'(overrun), 48'h0);
    chk("rst_frame_err", 48'(frame_err), 48'h0);
`ifdef I2S_RX_ERR_CNT_EN
    chk("rst_err_count", 48'(err_count), 48'h0);
`endif

    // Release with s_clk quiet
    s_clk = 1'b0; ws = 1'b0; sd = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_m_valid", 48'(m_valid), 48'h0);

    // Start mid-left then a full right slot: nothing may be emitted before sync
    for (int i = 0; i < 10; i++) send_bit(1'b0, i[0], 1'b0);
    send_slot(1'b1, 24'hDEADBE, 24, 7, 1'b0);
    chk("sync_no_pair", 48'(hq.size()), 48'h0);
    chk("sync_no_ferr", 48'(frame_err), 48'h0);

    // Table of frames with the consumer always ready
    for (int v = 0; v < 5; v++) begin
      pulse_clr();
      hq.delete();
      vcnt = 0;
      rise_cyc = -1;
      send_frame(vecs[v].l, vecs[v].r, vecs[v].lbits, 1'b0);
      chk($sformatf("v%0d_pairs", v), 48'(hq.size()), 48'(vecs[v].exp_n));
      chk($sformatf("v%0d_valid_cycles", v), 48'(vcnt), 48'(vecs[v].exp_n));
      chk($sformatf("v%0d_frame_err", v), 48'(frame_err), 48'(vecs[v].exp_ferr));
      chk($sformatf("v%0d_overrun", v), 48'(overrun), 48'h0);
      if (vecs[v].exp_n > 0 && hq.size() > 0) begin
        chk($sformatf("v%0d_pair", v), hq[0], {vecs[v].exp_l, vecs[v].exp_r});
        chk($sformatf("v%0d_latency_ok", v),
            48'((rise_cyc - lsb_cyc >= 3) && (rise_cyc - lsb_cyc <= 5)), 48'h1);
      end
    end

    // Backpressure across two frames
    m_ready = 1'b0;
    pulse_clr();
    hq.delete();
    send_frame(24'h000001, 24'h000002, 24, 1'b0);
    send_frame(24'h000003, 24'h000004, 24, 1'b0);
    chk("bp_m_valid", 48'(m_valid), 48'h1);
    chk("bp_held_pair", {m_left, m_right}, {24'h000001, 24'h000002});
    chk("bp_overrun", 48'(overrun), 48'h1);
    chk("bp_no_handshake", 48'(hq.size()), 48'h0);
`ifdef I2S_RX_ERR_CNT_EN
    chk("bp_err_count", 48'(err_count), 48'h1);
`endif
    pulse_clr();
    chk("bp_overrun_cleared", 48'(overrun), 48'h0);
    chk("bp_still_held", {m_left, m_right}, {24'h000001, 24'h000002});
`ifdef I2S_RX_ERR_CNT_EN
    chk("bp_err_count_cleared", 48'(err_count), 48'h0);
`endif

    // Handshake of held pair in exactly the cycle the next pair forms
    send_frame(24'h000007, 24'h000008, 24, 1'b1);
    chk("co_handshake_count", 48'(hq.size()), 48'h1);
    if (hq.size() > 0) chk("co_drained_pair", hq[0], {24'h000001, 24'h000002});
    chk("co_m_valid", 48'(m_valid), 48'h1);
    chk("co_new_pair", {m_left, m_right}, {24'h000007, 24'h000008});
    chk("co_overrun", 48'(overrun), 48'h0);

    // Drain and confirm m_valid falls the cycle after the handshake
    m_ready = 1'b1;
    @(negedge clk);
    chk("drain_m_valid_low", 48'(m_valid), 48'h0);
    chk("drain_pair", hq[hq.size()-1], {24'h000007, 24'h000008});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
